block_beat_serdes: RTL and testbench

- Bidirectional cache-line beat converter between the cache and the AXI master.
- FILL mode: collects BEATS consecutive AXI read beats into one block, LSB beat first.
- DRAIN mode: emits a stored block as BEATS write beats, LSB beat first, with valid/ready handshake and a last flag.
- Tracks beats with its own counter, reports busy/done, and generalises the earlier single-direction shift register to any legal width ratio.

---
 rtl/block_beat_serdes.sv | 137 +++++++++++++
 tb/tb_block_beat_serdes.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_beat_serdes.sv
// Bidirectional cache-line beat converter between the cache and the AXI master.
// FILL collects BEATS read beats into one block (LSB beat first); DRAIN emits a
// stored block as BEATS write beats (LSB beat first) with valid/ready and last.
// Optional feature macro: BLOCK_SERDES_ROTATE_EN -- DRAIN rotates the block
// instead of zero-filling it, so the line is intact after drain_done_o.
module block_beat_serdes #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH    = 512
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      fill_start_i,
    input  logic                      drain_start_i,
    input  logic [BLOCK_WIDTH-1:0]    data_block_i,
    input  logic [AXI_DATA_WIDTH-1:0] rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    output logic [AXI_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    output logic                      wr_last_o,
    output logic [BLOCK_WIDTH-1:0]    data_block_o,
    output logic                      busy_o,
    output logic                      fill_done_o,
    output logic                      drain_done_o
);

    localparam int unsigned BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

    // Reject width ratios that cannot be split into at least two whole beats.
    if ((BLOCK_WIDTH % AXI_DATA_WIDTH) != 0 || BEATS < 2) begin : gen_param_check
        $error("BLOCK_WIDTH must be an integer multiple (>= 2) of AXI_DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDrain
    } state_e;

    state_e                   state_q, state_d;
    logic [BLOCK_WIDTH-1:0]   block_q, block_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     fill_done_q, fill_done_d;
    logic                     drain_done_q, drain_done_d;
    logic [AXI_DATA_WIDTH-1:0] drain_refill;

    // Word shifted into the top of the block on each accepted write beat.
`ifdef BLOCK_SERDES_ROTATE_EN
    assign drain_refill = block_q[AXI_DATA_WIDTH-1:0];
`else
    assign drain_refill = '0;
`endif

    // State, block, beat counter and done pulses; async reset aborts any transfer.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= StIdle;
            block_q      <= '0;
            cnt_q        <= '0;
            fill_done_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            block_q      <= block_d;
            cnt_q        <= cnt_d;
            fill_done_q  <= fill_done_d;
            drain_done_q <= drain_done_d;
        end
    end

    // Next-state logic: start decode in IDLE, shift/count on each beat handshake.
    always_comb begin
        state_d      = state_q;
        block_d      = block_q;
        cnt_d        = cnt_q;
        fill_done_d  = 1'b0;
        drain_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Drain has priority when both starts arrive together.
                if (drain_start_i) begin
                    block_d = data_block_i;
                    cnt_d   = '0;
                    state_d = StDrain;
                end else if (fill_start_i) begin
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                if (rd_valid_i) begin
                    block_d = {rd_data_i, block_q[BLOCK_WIDTH-1:AXI_DATA_WIDTH]};
                    if (cnt_q == LastBeat) begin
                        cnt_d       = '0;
                        state_d     = StIdle;
                        fill_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDrain: begin
                if (wr_ready_i) begin
                    block_d = {drain_refill, block_q[BLOCK_WIDTH-1:AXI_DATA_WIDTH]};
                    if (cnt_q == LastBeat) begin
                        cnt_d        = '0;
                        state_d      = StIdle;
                        drain_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        rd_ready_o = (state_q == StFill);
        wr_valid_o = (state_q == StDrain);
        wr_data_o  = (state_q == StDrain) ? block_q[AXI_DATA_WIDTH-1:0] : '0;
        wr_last_o  = (state_q == StDrain) && (cnt_q == LastBeat);
        busy_o     = (state_q != StIdle);
    end

    assign data_block_o = block_q;
    assign fill_done_o  = fill_done_q;
    assign drain_done_o = drain_done_q;

endmodule

// File: tb/tb_block_beat_serdes.sv
// Self-checking bench for block_beat_serdes (32-bit beats, 128-bit block).
// Expected values come from a beat-level model: a block is a list of BEATS words,
// LSB word first; FILL must assemble it, DRAIN must emit it in order.
module tb_block_beat_serdes;

    localparam int unsigned W  = 32;
    localparam int unsigned BW = 128;
    localparam int unsigned NB = BW / W;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic          fill_start_i;
    logic          drain_start_i;
    logic [BW-1:0] data_block_i;
    logic [W-1:0]  rd_data_i;
    logic          rd_valid_i;
    logic          rd_ready_o;
    logic [W-1:0]  wr_data_o;
    logic          wr_valid_o;
    logic          wr_ready_i;
    logic          wr_last_o;
    logic [BW-1:0] data_block_o;
    logic          busy_o;
    logic          fill_done_o;
    logic          drain_done_o;

    int total = 0;
    int bad   = 0;

    // Block left in the register after a complete drain of blk.
    function automatic logic [BW-1:0] after_drain(input logic [BW-1:0] blk);
`ifdef BLOCK_SERDES_ROTATE_EN
        return blk;
`else
        return '0;
`endif
    endfunction

    block_beat_serdes #(
        .AXI_DATA_WIDTH(W),
        .BLOCK_WIDTH   (BW)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .fill_start_i (fill_start_i),
        .drain_start_i(drain_start_i),
        .data_block_i (data_block_i),
        .rd_data_i    (rd_data_i),
        .rd_valid_i   (rd_valid_i),
        .rd_ready_o   (rd_ready_o),
        .wr_data_o    (wr_data_o),
        .wr_valid_o   (wr_valid_o),
        .wr_ready_i   (wr_ready_i),
        .wr_last_o    (wr_last_o),
        .data_block_o (data_block_o),
        .busy_o       (busy_o),
        .fill_done_o  (fill_done_o),
        .drain_done_o (drain_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // n idle cycles with random handshake inputs; nothing may move.
    task automatic test_idle(input int n, input logic [BW-1:0] exp_blk, input string tag);
        for (int c = 0; c < n; c++) begin
            rd_valid_i = 1'($urandom_range(0, 1));
            rd_data_i  = $urandom();
            wr_ready_i = 1'($urandom_range(0, 1));
            #1;
            total++;
            if ({busy_o, rd_ready_o, wr_valid_o, wr_last_o, fill_done_o, drain_done_o} !== 6'b0) begin
                bad++;
                $display("FAIL %s idle flags cyc %0d: got busy=%b rdy=%b wv=%b wl=%b fd=%b dd=%b want all 0",
                         tag, c, busy_o, rd_ready_o, wr_valid_o, wr_last_o, fill_done_o, drain_done_o);
            end
            total++;
            if (wr_data_o !== '0) begin
                bad++;
                $display("FAIL %s idle wr_data cyc %0d: got %h want 0", tag, c, wr_data_o);
            end
            total++;
            if (data_block_o !== exp_blk) begin
                bad++;
                $display("FAIL %s idle block cyc %0d: got %h want %h", tag, c, data_block_o, exp_blk);
            end
            next_cycle();
        end
        rd_valid_i = 1'b0;
        wr_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        arst_i        = 1'b1;
        fill_start_i  = 1'b0;
        drain_start_i = 1'b0;
        data_block_i  = '0;
        rd_data_i     = '0;
        rd_valid_i    = 1'b0;
        wr_ready_i    = 1'b0;
        repeat (3) next_cycle();
        arst_i = 1'b0;
        test_idle(10, '0, "reset");
    endtask

    // Fill with the beats of blk (LSB first); ends in the fill_done cycle.
    task automatic test_fill(input logic [BW-1:0] blk, input bit stalls, input string tag);
        int i     = 0;
        int guard = 0;
        int stall = 0;
        logic v;
        fill_start_i = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || rd_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s start cycle: got busy=%b rdy=%b want 0 0", tag, busy_o, rd_ready_o);
        end
        next_cycle();
        fill_start_i = 1'b0;
        while (i < NB && guard < 200) begin
            v = stalls ? (1'($urandom_range(0, 1)) | (stall >= 3)) : 1'b1;
            rd_valid_i = v;
            rd_data_i  = v ? blk[i*W +: W] : $urandom();
            #1;
            total++;
            if (rd_ready_o !== 1'b1 || busy_o !== 1'b1 || wr_valid_o !== 1'b0 || fill_done_o !== 1'b0) begin
                bad++;
                $display("FAIL %s beat %0d: got rdy=%b busy=%b wv=%b fd=%b want 1 1 0 0",
                         tag, i, rd_ready_o, busy_o, wr_valid_o, fill_done_o);
            end
            next_cycle();
            if (v) begin
                i++;
                stall = 0;
            end else begin
                stall++;
            end
            guard++;
        end
        rd_valid_i = 1'b0;
        #1;
        total++;
        if (i != NB) begin
            bad++;
            $display("FAIL %s timeout: got %0d beats want %0d", tag, i, NB);
        end
        total++;
        if (fill_done_o !== 1'b1 || busy_o !== 1'b0 || rd_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s done: got fd=%b busy=%b rdy=%b want 1 0 0", tag, fill_done_o, busy_o, rd_ready_o);
        end
        total++;
        if (data_block_o !== blk) begin
            bad++;
            $display("FAIL %s block: got %h want %h", tag, data_block_o, blk);
        end
    endtask

    // Drain blk. mode 0: always ready, 1: toggle 1,0,.., 2: random.
    // both_start raises fill_start_i with drain_start_i; fill_during holds it through the drain.
    task automatic test_drain(input logic [BW-1:0] blk, input int mode, input bit both_start,
                              input bit fill_during, input string tag);
        int i     = 0;
        int guard = 0;
        int stall = 0;
        logic r;
        drain_start_i = 1'b1;
        fill_start_i  = both_start;
        data_block_i  = blk;
        #1;
        total++;
        if (busy_o !== 1'b0 || wr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s start cycle: got busy=%b wv=%b want 0 0", tag, busy_o, wr_valid_o);
        end
        next_cycle();
        drain_start_i = 1'b0;
        fill_start_i  = fill_during;
        data_block_i  = rand_block();
        while (i < NB && guard < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (guard % 2 == 0);
                default: r = 1'($urandom_range(0, 1)) | (stall >= 3);
            endcase
            wr_ready_i = r;
            rd_valid_i = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (wr_valid_o !== 1'b1 || busy_o !== 1'b1 || rd_ready_o !== 1'b0 || drain_done_o !== 1'b0) begin
                bad++;
                $display("FAIL %s beat %0d flags: got wv=%b busy=%b rdy=%b dd=%b want 1 1 0 0",
                         tag, i, wr_valid_o, busy_o, rd_ready_o, drain_done_o);
            end
            total++;
            if (wr_data_o !== blk[i*W +: W]) begin
                bad++;
                $display("FAIL %s beat %0d data: got %h want %h", tag, i, wr_data_o, blk[i*W +: W]);
            end
            total++;
            if (wr_last_o !== (i == NB - 1)) begin
                bad++;
                $display("FAIL %s beat %0d last: got %b want %b", tag, i, wr_last_o, (i == NB - 1));
            end
            next_cycle();
            if (r) begin
                i++;
                stall = 0;
            end else begin
                stall++;
            end
            guard++;
        end
        wr_ready_i   = 1'b0;
        rd_valid_i   = 1'b0;
        fill_start_i = 1'b0;
        #1;
        total++;
        if (i != NB) begin
            bad++;
            $display("FAIL %s timeout: got %0d beats want %0d", tag, i, NB);
        end
        total++;
        if (drain_done_o !== 1'b1 || busy_o !== 1'b0 || wr_valid_o !== 1'b0 || wr_data_o !== '0) begin
            bad++;
            $display("FAIL %s done: got dd=%b busy=%b wv=%b wd=%h want 1 0 0 0",
                     tag, drain_done_o, busy_o, wr_valid_o, wr_data_o);
        end
        total++;
        if (data_block_o !== after_drain(blk)) begin
            bad++;
            $display("FAIL %s end block: got %h want %h", tag, data_block_o, after_drain(blk));
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [BW-1:0] blk;
        blk = rand_block();
        fill_start_i = 1'b1;
        next_cycle();
        fill_start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_valid_i = 1'b1;
            rd_data_i  = blk[k*W +: W];
            next_cycle();
        end
        arst_i = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || rd_ready_o !== 1'b0 || data_block_o !== '0 || fill_done_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid in reset: got busy=%b rdy=%b blk=%h fd=%b want 0 0 0 0",
                     busy_o, rd_ready_o, data_block_o, fill_done_o);
        end
        next_cycle();
        arst_i     = 1'b0;
        rd_valid_i = 1'b1;
        test_idle(4, '0, "rst_mid");
        test_fill(blk, 1'b0, "rst_refill");
    endtask

    task automatic test_back_to_back();
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        a = rand_block();
        b = rand_block();
        // Each new start lands in the done cycle of the previous operation.
        test_fill(a, 1'b1, "b2b_fill");
        test_drain(b, 2, 1'b0, 1'b0, "b2b_drain");
        test_fill(a, 1'b0, "b2b_fill2");
        next_cycle();
        test_idle(2, a, "b2b_idle");
    endtask

    task automatic test_random(input int n);
        logic [BW-1:0] blk;
        for (int k = 0; k < n; k++) begin
            blk = rand_block();
            if ($urandom_range(0, 1) == 1) begin
                test_fill(blk, 1'b1, "rnd_fill");
                next_cycle();
                test_idle(1, blk, "rnd_fill_idle");
            end else begin
                test_drain(blk, 2, 1'b0, 1'b0, "rnd_drain");
                next_cycle();
                test_idle(1, after_drain(blk), "rnd_drain_idle");
            end
        end
    endtask

    initial begin
        logic [BW-1:0] fill_blk;
        logic [BW-1:0] drain_blk;
        fill_blk  = 128'h00000044_00000033_00000022_00000011;
        drain_blk = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

        test_reset();

        test_fill(fill_blk, 1'b0, "fill_dir");
        next_cycle();
        test_idle(2, fill_blk, "fill_dir_idle");

        test_drain(drain_blk, 1, 1'b0, 1'b0, "drain_toggle");
        next_cycle();
        test_idle(2, after_drain(drain_blk), "drain_toggle_idle");

        test_drain(drain_blk, 0, 1'b1, 1'b0, "both_start");
        next_cycle();
        test_idle(3, after_drain(drain_blk), "both_start_idle");

        test_reset_mid_fill();
        next_cycle();

        test_drain(drain_blk, 2, 1'b0, 1'b1, "fill_in_drain");
        next_cycle();
        test_idle(3, after_drain(drain_blk), "fill_in_drain_idle");

        test_back_to_back();
        test_random(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
